// File: rtl/steer_en_ctrl.sv
// Rider-detect / steering-enable FSM over left/right load-cell readings with weight hysteresis and balance timer.
// Latency: outputs registered, change one clk after the input condition; STEER reached TMR_CYCLES clks after WAIT entry.
// Backpressure: none; inputs are sampled every clk and the block never stalls its source.
module steer_en_ctrl #(
    parameter logic [11:0] MIN_RIDER_WT = 12'h200,
    parameter logic [11:0] WT_HYST      = 12'h040,
    parameter logic [25:0] TMR_CYCLES   = 26'd65_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [11:0] lft_ld,
    input  logic [11:0] rght_ld,
    output logic        en_steer,
    output logic        rider_off
);

    typedef enum logic [1:0] {
        S_OFF   = 2'd0,
        S_WAIT  = 2'd1,
        S_STEER = 2'd2
    } state_t;

    state_t      state;
    state_t      nxt_state;
    logic        tmr_clr;
    logic [25:0] tmr;
    logic        tmr_full;

    logic [12:0] sum;
    logic [11:0] diff;
    logic [12:0] sum_15_16;
    logic [12:0] min_wt;
    logic [12:0] lost_wt;
    logic        sum_gt_min;
    logic        sum_lt_min;
    logic        diff_gt_1_4;
    logic        diff_gt_15_16;

    // Threshold constants widened once so every compare below is 13-bit unsigned.
    assign min_wt  = {1'b0, MIN_RIDER_WT};
    assign lost_wt = {1'b0, MIN_RIDER_WT - WT_HYST};

    // Weight and balance metrics evaluated directly on the registered A2D inputs.
    always_comb begin
        sum  = {1'b0, lft_ld} + {1'b0, rght_ld};
        diff = (lft_ld >= rght_ld) ? (lft_ld - rght_ld) : (rght_ld - lft_ld);
        // 15/16 of sum, truncated: sum minus sum/16.
        sum_15_16     = sum - {4'b0000, sum[12:4]};
        sum_gt_min    = (sum > min_wt);
        sum_lt_min    = (sum < lost_wt);
        diff_gt_1_4   = ({1'b0, diff} > {2'b00, sum[12:2]});
        diff_gt_15_16 = ({1'b0, diff} > sum_15_16);
    end

    assign tmr_full = (tmr == (TMR_CYCLES - 26'd1));

    // Qualification timer: cleared on request from the FSM, counts only while waiting for balance.
    always_ff @(posedge clk) begin
        if (rst) begin
            tmr <= '0;
        end else if (tmr_clr) begin
            tmr <= '0;
        end else if (state == S_WAIT) begin
            tmr <= tmr + 26'd1;
        end
    end

    // Next-state logic; weight loss is checked first so it wins over imbalance and timer.
    always_comb begin
        nxt_state = state;
        tmr_clr   = 1'b0;
        case (state)
            S_OFF: begin
                tmr_clr = 1'b1;
                if (sum_gt_min) begin
                    nxt_state = S_WAIT;
                end
            end
            S_WAIT: begin
                if (sum_lt_min) begin
                    nxt_state = S_OFF;
                end else if (diff_gt_1_4) begin
                    tmr_clr = 1'b1;
                end else if (tmr_full) begin
                    nxt_state = S_STEER;
                end
            end
            S_STEER: begin
                if (sum_lt_min) begin
                    nxt_state = S_OFF;
                end else if (diff_gt_15_16) begin
                    nxt_state = S_WAIT;
                    tmr_clr   = 1'b1;
                end
            end
            default: begin
                nxt_state = S_OFF;
                tmr_clr   = 1'b1;
            end
        endcase
    end

    // State register with outputs decoded from the next state so they are flop outputs, glitch-free.
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_OFF;
            rider_off <= 1'b1;
            en_steer  <= 1'b0;
        end else begin
            state     <= nxt_state;
            rider_off <= (nxt_state == S_OFF);
            en_steer  <= (nxt_state == S_STEER);
        end
    end

endmodule

// File: tb/tb_steer_en_ctrl.sv
// Directed bench for steer_en_ctrl with a short qualification timer.
// Each stimulus cycle queues the expected {rider_off, en_steer}; it is popped and checked after the edge.
// Inputs are driven and outputs sampled 1 time unit after the rising edge.
module tb_steer_en_ctrl;

    logic        clk;
    logic        rst;
    logic [11:0] lft_ld;
    logic [11:0] rght_ld;
    logic        en_steer;
    logic        rider_off;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0] exp_q[$];
    string      tag_q[$];

    steer_en_ctrl #(
        .MIN_RIDER_WT(12'h200),
        .WT_HYST     (12'h040),
        .TMR_CYCLES  (26'd16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .lft_ld   (lft_ld),
        .rght_ld  (rght_ld),
        .en_steer (en_steer),
        .rider_off(rider_off)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pop the oldest expectation and compare against the DUT outputs.
    task automatic check_out();
        logic [1:0] obs;
        logic [1:0] exp_v;
        string      tag;
        obs = {rider_off, en_steer};
        n_checks++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL scoreboard_empty: observed off/en=%b expected an entry", obs);
        end else begin
            exp_v = exp_q.pop_front();
            tag   = tag_q.pop_front();
            assert (obs === exp_v) else begin
                n_fail++;
                $error("FAIL %s: observed off/en=%b expected off/en=%b", tag, obs, exp_v);
            end
        end
    endtask

    // One clock of stimulus with its expected post-edge outputs.
    task automatic cyc(input logic [11:0] l, input logic [11:0] r, input logic rs,
                       input logic exp_off, input logic exp_en, input string tag);
        lft_ld  = l;
        rght_ld = r;
        rst     = rs;
        exp_q.push_back({exp_off, exp_en});
        tag_q.push_back(tag);
        @(posedge clk);
        #1;
        check_out();
    endtask

    // From OFF (or just-cleared WAIT): n_wait cycles in WAIT, then en_steer on the next edge.
    task automatic to_steer(input logic [11:0] l, input logic [11:0] r, input int n_wait, input string tag);
        for (int i = 0; i < n_wait; i++) cyc(l, r, 1'b0, 1'b0, 1'b0, {tag, "_wait"});
        cyc(l, r, 1'b0, 1'b0, 1'b1, {tag, "_steer"});
    endtask

    // Absolute time bound so the run can never hang.
    initial begin
        #200000;
        $display("FAIL watchdog: observed simulation still running expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        lft_ld  = 12'h000;
        rght_ld = 12'h000;
        rst     = 1'b1;

        // 1. Reset with a heavy rider already standing, then release.
        cyc(12'h300, 12'h300, 1'b1, 1'b1, 1'b0, "rst_c0");
        cyc(12'h300, 12'h300, 1'b1, 1'b1, 1'b0, "rst_c1");
        to_steer(12'h300, 12'h300, 16, "rst_release");
        cyc(12'h300, 12'h300, 1'b0, 1'b0, 1'b1, "rst_hold_steer");

        // 2. Step off, then step on balanced from OFF.
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0, "stepoff");
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0, "off_idle");
        to_steer(12'h150, 12'h150, 16, "stepon");
        for (int i = 0; i < 5; i++) cyc(12'h150, 12'h150, 1'b0, 1'b0, 1'b1, "stepon_hold");

        // 3. Imbalance holds the timer in WAIT for 100 cycles, then balance.
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0, "imb_off");
        for (int i = 0; i < 100; i++) cyc(12'h200, 12'h0A0, 1'b0, 1'b0, 1'b0, "imb_hold");
        to_steer(12'h150, 12'h150, 15, "imb_release");

        // 4. Imbalance within 15/16 keeps STEER; beyond it drops to WAIT.
        for (int i = 0; i < 4; i++) cyc(12'h200, 12'h0A0, 1'b0, 1'b0, 1'b1, "steer_mild_imb");
        cyc(12'h290, 12'h010, 1'b0, 1'b0, 1'b0, "steer_to_wait");
        cyc(12'h290, 12'h010, 1'b0, 1'b0, 1'b0, "wait_imb_stay");

        // 5A. Hysteresis band and exact threshold do not leave OFF.
        cyc(12'h000, 12'h000, 1'b0, 1'b1, 1'b0, "hyst_off");
        for (int i = 0; i < 3; i++) cyc(12'h0F8, 12'h0F8, 1'b0, 1'b1, 1'b0, "hyst_band_off");
        for (int i = 0; i < 3; i++) cyc(12'h100, 12'h100, 1'b0, 1'b1, 1'b0, "hyst_eq_min_off");

        // 5B. Band lower edge keeps STEER; 5C. one below drops to OFF.
        to_steer(12'h150, 12'h150, 16, "hyst_climb");
        for (int i = 0; i < 3; i++) cyc(12'h0E0, 12'h0E0, 1'b0, 1'b0, 1'b1, "hyst_band_steer");
        cyc(12'h0E0, 12'h0DF, 1'b0, 1'b1, 1'b0, "hyst_below_off");

        // 6. Reset mid-count restarts a full qualification.
        for (int i = 0; i < 11; i++) cyc(12'h150, 12'h150, 1'b0, 1'b0, 1'b0, "mid_wait");
        cyc(12'h150, 12'h150, 1'b1, 1'b1, 1'b0, "mid_rst");
        to_steer(12'h150, 12'h150, 16, "mid_restart");

        if (exp_q.size() != 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL scoreboard_leftover: observed %0d entries expected 0", exp_q.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
